segment_text_scroller: RTL and testbench

- Upstream feeder for the two-digit seven-segment character decoders.
- Stores a short ASCII message written over a valid/ready byte interface.
- Scrolls the message right-to-left across a two-character window at a programmable rate.
- o_char_left and o_char_right drive the left and right character decoders directly.

---
 rtl/segment_text_scroller_pkg.sv | 13 +
 rtl/scroll_tick_divider.sv | 30 +++
 rtl/segment_text_scroller.sv | 129 ++++++++++++
 tb/tb_segment_text_scroller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/segment_text_scroller_pkg.sv
// Shared display definitions for the seven-segment character feeders.
package segment_text_scroller_pkg;

   localparam int CHAR_W = 8;
   localparam logic [CHAR_W-1:0] BLANK_CHAR_DEFAULT = 8'h20;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SCROLL = 2'd2
   } scrollState_e;

endpackage

// File: rtl/scroll_tick_divider.sv
// Enable-gated modulo-DIV counter; o_tick marks the enabled cycle that wraps it.
module scroll_tick_divider #(
   parameter int DIV = 6250000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_restart,
   input  logic i_enable,
   output logic o_tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] divCount;

   // Restart wins over the wrap so a restarted divider never emits a stray tick.
   assign o_tick = i_enable && !i_restart && (divCount == LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         divCount <= '0;
      end else if (i_restart) begin
         divCount <= '0;
      end else if (i_enable) begin
         divCount <= o_tick ? '0 : divCount + W'(1);
      end
   end

endmodule

// File: rtl/segment_text_scroller.sv
// Stores a short ASCII message and scrolls it right-to-left through a
// two-character window feeding the left/right seven-segment decoders.
module segment_text_scroller
   import segment_text_scroller_pkg::*;
#(
   parameter int                MAX_LEN    = 16,
   parameter int                SCROLL_DIV = 6250000,
   parameter logic [CHAR_W-1:0] BLANK_CHAR = BLANK_CHAR_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_valid,
   input  logic [CHAR_W-1:0] i_wr_char,
   input  logic              i_wr_last,
   output logic              o_wr_ready,
   input  logic              i_clear,
   input  logic              i_enable,
   output logic [CHAR_W-1:0] o_char_left,
   output logic [CHAR_W-1:0] o_char_right,
   output logic              o_step,
   output logic              o_scrolling
);

   localparam int CW = $clog2(MAX_LEN + 1);
   localparam int IW = $clog2(MAX_LEN + 2);
   localparam int AW = $clog2(MAX_LEN);

   scrollState_e      state, stateN;
   logic [CW-1:0]     count, countN;
   logic [CW-1:0]     len, lenN;
   logic [IW-1:0]     idx, idxN;
   logic [CHAR_W-1:0] mem [MAX_LEN];

   logic              accept;
   logic              finalWr;
   logic              tick;
   logic [IW-1:0]     lastIdx;
   logic [IW-1:0]     lastIdxN;
   logic [IW-1:0]     rightPos;
   logic [CHAR_W-1:0] leftN, rightN;

   // Handshake: a character transfers on a cycle where i_wr_valid and
   // o_wr_ready are both high; ready is combinational, drops in SCROLL and
   // whenever i_clear is asserted, so a clear always swallows the write.
   assign o_wr_ready = (state != SCROLL) && !i_clear;
   assign accept     = i_wr_valid && o_wr_ready;
   assign finalWr    = accept && (i_wr_last || (count == CW'(MAX_LEN - 1)));

   scroll_tick_divider #(
      .DIV (SCROLL_DIV)
   ) u_divider (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_restart (i_clear || (state != SCROLL)),
      .i_enable  (i_enable),
      .o_tick    (tick)
   );

   assign lastIdx = IW'(len) + IW'(1);

   always_comb begin
      stateN = state;
      countN = count;
      lenN   = len;
      idxN   = idx;
      if (i_clear) begin
         stateN = IDLE;
         countN = '0;
         lenN   = '0;
         idxN   = '0;
      end else if (accept) begin
         countN = count + CW'(1);
         stateN = finalWr ? SCROLL : LOAD;
         if (finalWr) begin
            lenN = count + CW'(1);
            idxN = '0;
         end
      end else if (state == SCROLL && tick) begin
         idxN = (idx == lastIdx) ? '0 : idx + IW'(1);
      end
   end

   // The window registers load from next-state values, so the character
   // being written on the final accept has to bypass the array.
   assign lastIdxN = IW'(lenN) + IW'(1);
   assign rightPos = (idxN == lastIdxN) ? '0 : idxN + IW'(1);

   always_comb begin
      leftN  = BLANK_CHAR;
      rightN = BLANK_CHAR;
      if (stateN == SCROLL) begin
         if (idxN < IW'(lenN)) begin
            leftN = (accept && idxN == IW'(count)) ? i_wr_char : mem[idxN[AW-1:0]];
         end
         if (rightPos < IW'(lenN)) begin
            rightN = (accept && rightPos == IW'(count)) ? i_wr_char : mem[rightPos[AW-1:0]];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         mem[count[AW-1:0]] <= i_wr_char;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         count        <= '0;
         len          <= '0;
         idx          <= '0;
         o_char_left  <= BLANK_CHAR;
         o_char_right <= BLANK_CHAR;
         o_step       <= 1'b0;
         o_scrolling  <= 1'b0;
      end else begin
         state        <= stateN;
         count        <= countN;
         len          <= lenN;
         idx          <= idxN;
         o_char_left  <= leftN;
         o_char_right <= rightN;
         o_step       <= tick;
         o_scrolling  <= (stateN == SCROLL);
      end
   end

endmodule

// File: tb/tb_segment_text_scroller.sv
// Randomized and directed bench for segment_text_scroller against a queue-based message model.
module tb_segment_text_scroller;

   localparam int MAX_LEN = 16;
   localparam int DIV     = 4;
   localparam logic [7:0] BL = 8'h20;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       wrValid = 1'b0;
   logic [7:0] wrChar = 8'h00;
   logic       wrLast = 1'b0;
   logic       clear = 1'b0;
   logic       enable = 1'b0;
   logic       wrReady;
   logic [7:0] charLeft, charRight;
   logic       step, scrolling;

   always #5 clk = ~clk;

   segment_text_scroller #(
      .MAX_LEN    (MAX_LEN),
      .SCROLL_DIV (DIV),
      .BLANK_CHAR (BL)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_wr_valid   (wrValid),
      .i_wr_char    (wrChar),
      .i_wr_last    (wrLast),
      .o_wr_ready   (wrReady),
      .i_clear      (clear),
      .i_enable     (enable),
      .o_char_left  (charLeft),
      .o_char_right (charRight),
      .o_step       (step),
      .o_scrolling  (scrolling)
   );

   int checkCnt = 0;
   int errCnt   = 0;
   int stepSeen = 0;

   // Reference model: message as a queue, window position within message+2 blanks.
   int         mPhase;   // 0 empty, 1 loading, 2 scrolling
   logic [7:0] mMsg[$];
   int         mPos;
   int         mEnCnt;
   bit         mStep;
   logic [17:0] exp_q[$];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] seqAt(input int i);
      return (i < mMsg.size()) ? mMsg[i] : BL;
   endfunction

   task automatic modelReset();
      mPhase = 0;
      mMsg.delete();
      mPos   = 0;
      mEnCnt = 0;
      mStep  = 0;
   endtask

   task automatic modelEdge(input logic v, input logic [7:0] c, input logic l,
                            input logic clr, input logic en);
      int p;
      mStep = 0;
      if (clr) begin
         modelReset();
      end else if (mPhase == 2) begin
         if (en) begin
            mEnCnt++;
            if (mEnCnt == DIV) begin
               mEnCnt = 0;
               mPos   = (mPos + 1) % (mMsg.size() + 2);
               mStep  = 1;
            end
         end
      end else if (v) begin
         mMsg.push_back(c);
         mPhase = 1;
         if (l || mMsg.size() == MAX_LEN) begin
            mPhase = 2;
            mPos   = 0;
            mEnCnt = 0;
         end
      end
      p = mMsg.size() + 2;
      if (mPhase == 2) exp_q.push_back({1'b1, mStep, seqAt(mPos), seqAt((mPos + 1) % p)});
      else             exp_q.push_back({1'b0, mStep, BL, BL});
   endtask

   task automatic checkWindow();
      logic [17:0] e;
      e = exp_q.pop_front();
      checkVal("left",      32'(charLeft),  32'(e[15:8]));
      checkVal("right",     32'(charRight), 32'(e[7:0]));
      checkVal("step",      32'(step),      32'(e[16]));
      checkVal("scrolling", 32'(scrolling), 32'(e[17]));
   endtask

   task automatic cycle(input logic v, input logic [7:0] c, input logic l,
                        input logic clr, input logic en);
      @(negedge clk);
      wrValid = v;
      wrChar  = c;
      wrLast  = l;
      clear   = clr;
      enable  = en;
      #1;
      checkVal("ready", 32'(wrReady), 32'((mPhase != 2) && !clr));
      @(posedge clk);
      modelEdge(v, c, l, clr, en);
      #1;
      checkWindow();
      stepSeen += int'(step);
   endtask

   task automatic idle(input int n, input logic en);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, en);
   endtask

   task automatic writeMsg(input string s, input bit withLast);
      for (int i = 0; i < s.len(); i++)
         cycle(1'b1, s[i], withLast && (i == s.len() - 1), 1'b0, 1'b1);
   endtask

   initial begin
      modelReset();
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkVal("rstLeft",  32'(charLeft),  32'(BL));
      checkVal("rstScroll", 32'(scrolling), 32'(0));
      @(negedge clk);
      rstN = 1'b1;
      #1;
      checkVal("relLeft",  32'(charLeft),  32'(BL));
      checkVal("relRight", 32'(charRight), 32'(BL));
      checkVal("relReady", 32'(wrReady),   32'(1));
      checkVal("relStep",  32'(step),      32'(0));
      checkVal("relScroll", 32'(scrolling), 32'(0));

      // HELLO through a full period
      writeMsg("HELLO", 1'b1);
      checkVal("firstWin", 32'({charLeft, charRight}), 32'({8'h48, 8'h45}));
      stepSeen = 0;
      idle(7 * DIV, 1'b1);
      checkVal("stepCount", 32'(stepSeen), 32'(7));
      checkVal("wrapHE", 32'({charLeft, charRight}), 32'({8'h48, 8'h45}));

      // Enable hold mid-step
      idle(2, 1'b1);
      stepSeen = 0;
      idle(10, 1'b0);
      checkVal("holdSteps", 32'(stepSeen), 32'(0));
      idle(1, 1'b1);
      checkVal("resumeNoStep", 32'(stepSeen), 32'(0));
      idle(1, 1'b1);
      checkVal("resumeStep", 32'(stepSeen), 32'(1));
      checkVal("resumeWin", 32'({charLeft, charRight}), 32'({8'h45, 8'h4C}));

      // Clear with a concurrent write while loading, then single-char message
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      writeMsg("XY", 1'b0);
      cycle(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
      checkVal("clrIdle", 32'({charLeft, charRight}), 32'({BL, BL}));
      writeMsg("A", 1'b1);
      checkVal("aWin0", 32'({charLeft, charRight}), 32'({8'h41, BL}));
      idle(3 * DIV + 2, 1'b1);

      // Overlong message: 17th character never accepted
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 17; i++)
         cycle(1'b1, 8'($urandom_range(33, 126)), 1'b0, 1'b0, 1'b1);
      checkVal("fullScroll", 32'(scrolling), 32'(1));
      idle(18 * DIV, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom_range(33, 126)),
               1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 80) == 0),
               1'($urandom_range(0, 3) != 0));

      // Asynchronous reset mid-scroll
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      writeMsg("GO", 1'b1);
      idle(2, 1'b1);
      checkVal("preRst", 32'(charLeft), 32'(8'h47));
      #2;
      rstN = 1'b0;
      #1;
      checkVal("asyncLeft",   32'(charLeft),  32'(BL));
      checkVal("asyncRight",  32'(charRight), 32'(BL));
      checkVal("asyncScroll", 32'(scrolling), 32'(0));
      @(negedge clk);
      rstN = 1'b1;
      modelReset();
      writeMsg("OK", 1'b1);
      idle(4 * DIV, 1'b1);

      $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
      $finish;
   end

endmodule
